// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFix,
      StDone
   } seq_mult_state_e;

   // Counter width able to hold the step count 0..w.
   function automatic int unsigned cnt_w(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Operand registers, W+1-bit adder, A/Q/R shift chain and final align/negate
// for the sequential multiplier. Control comes from seq_mult_param.
module seq_mult_datapath
   import seq_mult_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_load,
   input  logic                   i_step,
   input  logic                   i_signed,
   input  logic [W-1:0]           i_a,
   input  logic [W-1:0]           i_b,
   input  logic [cnt_w(W)-1:0]    i_steps,
   output logic                   o_r_done,
   output logic [2*W-1:0]         o_product
);

   localparam int unsigned CntW = cnt_w(W);

   logic [W:0]     a_q;
   logic [W-1:0]   q_q;
   logic [W-1:0]   m_q;
   logic [W-1:0]   r_q;
   logic           neg_q;

   logic [W-1:0]   a_mag;
   logic [W-1:0]   b_mag;
   logic [W:0]     sum;
   logic [CntW-1:0] shamt;
   logic [2*W-1:0] aligned;

   // The most-negative operand negates to itself, which reads correctly as unsigned.
   always_comb begin
      a_mag = (i_signed && i_a[W-1]) ? -i_a : i_a;
      b_mag = (i_signed && i_b[W-1]) ? -i_b : i_b;
   end

   always_comb begin
      sum = a_q + {1'b0, m_q & {W{q_q[0]}}};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_q   <= '0;
         q_q   <= '0;
         m_q   <= '0;
         r_q   <= '0;
         neg_q <= 1'b0;
      end else if (i_load) begin
         a_q   <= '0;
         q_q   <= b_mag;
         m_q   <= a_mag;
         r_q   <= b_mag;
         neg_q <= i_signed & (i_a[W-1] ^ i_b[W-1]);
      end else if (i_step) begin
         a_q <= {1'b0, sum[W:1]};
         q_q <= {sum[0], q_q[W-1:1]};
         r_q <= {1'b0, r_q[W-1:1]};
      end
   end

   // R tracks the unconsumed multiplier bits; this step is the last useful one
   // when nothing remains above the bit being consumed now.
   assign o_r_done = (r_q[W-1:1] == '0);

   // After k steps the partial product sits k bits below the top of {A,Q}.
   always_comb begin
      shamt     = CntW'(W) - i_steps;
      aligned   = {a_q[W-1:0], q_q} >> shamt;
      o_product = neg_q ? -aligned : aligned;
   end

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift-and-add multiplier with valid/ready on both sides, per-pair
// signed/unsigned mode, abort and optional early termination.
module seq_mult_param
   import seq_mult_pkg::*;
#(
   parameter int unsigned W          = 32,
   parameter bit          EARLY_EXIT = 1'b0
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic           i_signed,
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   input  logic           i_abort,
   output logic           o_valid,
   input  logic           i_ready,
   output logic [2*W-1:0] o_result,
   output logic           o_busy
);

   localparam int unsigned CntW = cnt_w(W);

   seq_mult_state_e state_q;
   logic [CntW-1:0] cnt_q;
   logic            valid_q;
   logic [2*W-1:0]  result_q;
   logic            busy_q;

   logic            accept;
   logic            step;
   logic            last_step;
   logic            r_done;
   logic [2*W-1:0]  product;

   assign accept    = (state_q == StIdle) && i_valid;
   assign step      = (state_q == StCalc) && !i_abort;
   assign last_step = (cnt_q == CntW'(W - 1)) || (EARLY_EXIT && r_done);

   seq_mult_datapath #(
      .W(W)
   ) u_datapath (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_load    (accept),
      .i_step    (step),
      .i_signed  (i_signed),
      .i_a       (i_a),
      .i_b       (i_b),
      .i_steps   (cnt_q),
      .o_r_done  (r_done),
      .o_product (product)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // A coincident abort is ignored here, so the accept wins.
               if (i_valid) begin
                  state_q <= StCalc;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StCalc: begin
               if (i_abort) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
                  if (last_step) begin
                     state_q <= StFix;
                  end
               end
            end
            StFix: begin
               if (i_abort) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  result_q <= product;
                  valid_q  <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= StDone;
               end
            end
            StDone: begin
               if (i_ready) begin
                  valid_q <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Gated by reset so the upstream stage never sees ready while held in reset.
   assign o_ready  = i_rst_n && (state_q == StIdle);
   assign o_valid  = valid_q;
   assign o_result = result_q;
   assign o_busy   = busy_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param: one full-latency instance and one with
// early exit, checked against an arithmetic reference model.
module tb_seq_mult_param;

   typedef struct {
      logic [63:0] res;
      int          due;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic [1:0]       valid;
   logic [1:0]       sgn;
   logic [1:0]       abrt;
   logic [1:0]       rdy;
   logic [1:0][31:0] a_in;
   logic [1:0][31:0] b_in;
   wire  [1:0]       oready;
   wire  [1:0]       ovalid;
   wire  [1:0]       obusy;
   wire  [1:0][63:0] ores;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          rmode    [2];
   bit          pv       [2];
   int          n_rise   [2];
   logic [63:0] last_res [2];
   exp_t        sb0 [$];
   exp_t        sb1 [$];

   seq_mult_param #(
      .W          (32),
      .EARLY_EXIT (1'b0)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_valid  (valid[0]),
      .o_ready  (oready[0]),
      .i_signed (sgn[0]),
      .i_a      (a_in[0]),
      .i_b      (b_in[0]),
      .i_abort  (abrt[0]),
      .o_valid  (ovalid[0]),
      .i_ready  (rdy[0]),
      .o_result (ores[0]),
      .o_busy   (obusy[0])
   );

   seq_mult_param #(
      .W          (32),
      .EARLY_EXIT (1'b1)
   ) dut_ee (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_valid  (valid[1]),
      .o_ready  (oready[1]),
      .i_signed (sgn[1]),
      .i_a      (a_in[1]),
      .i_b      (b_in[1]),
      .i_abort  (abrt[1]),
      .o_valid  (ovalid[1]),
      .i_ready  (rdy[1]),
      .o_result (ores[1]),
      .o_busy   (obusy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
      longint          x, y;
      longint unsigned ux, uy;
      if (s) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
         return 64'(x * y);
      end
      ux = {32'd0, a};
      uy = {32'd0, b};
      return ux * uy;
   endfunction

   function automatic int ref_k(input logic [31:0] b, input logic s, input bit ee);
      longint v;
      int     n;
      if (!ee) return 32;
      v = s ? longint'($signed(b)) : longint'({32'd0, b});
      if (v < 0) v = -v;
      n = 0;
      while (v != 0) begin
         n++;
         v = v >> 1;
      end
      return (n < 1) ? 1 : n;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 15));
         3:       return $urandom >> $urandom_range(0, 31);
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
      end
   endtask

   task automatic mon(input int d);
      exp_t e;
      bit   have;
      if (!rst_n) begin
         pv[d] = 1'b0;
         return;
      end
      if (ovalid[d]) begin
         if (!pv[d]) begin
            n_rise[d]++;
            have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
            if (!have) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_valid dut%0d: got result 0x%h, want no result", d,
                        ores[d]);
            end else begin
               if (d == 0) e = sb0.pop_front();
               else        e = sb1.pop_front();
               check($sformatf("result dut%0d", d), ores[d], e.res);
               check($sformatf("latency dut%0d", d), 64'(cyc), 64'(e.due));
            end
         end else begin
            check($sformatf("hold_result dut%0d", d), ores[d], last_res[d]);
         end
         check($sformatf("ready_low_in_done dut%0d", d), 64'(oready[d]), 64'd0);
         last_res[d] = ores[d];
      end else if (pv[d]) begin
         check($sformatf("keep_after_take dut%0d", d), ores[d], last_res[d]);
      end
      pv[d] = ovalid[d];
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   // Consumer: 0 = always ready, 1 = random, 2 = stall.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         case (rmode[d])
            0:       rdy[d] = 1'b1;
            1:       rdy[d] = 1'($urandom_range(0, 1));
            default: rdy[d] = 1'b0;
         endcase
      end
   end

   // Call in the low clock phase; returns in the low phase after the accept edge.
   task automatic drive(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ab, input bit want,
                        input logic [63:0] er, input int k, output int acc);
      int   guard;
      exp_t e;
      guard   = 0;
      a_in[d] = a;
      b_in[d] = b;
      sgn[d]  = s;
      abrt[d] = ab;
      valid[d] = 1'b1;
      while (!oready[d] && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!oready[d]) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout dut%0d: got o_ready 0, want 1 within 300 cycles", d);
         valid[d] = 1'b0;
         abrt[d]  = 1'b0;
         acc      = -1;
         return;
      end
      @(posedge clk);
      #1;
      acc      = cyc;
      valid[d] = 1'b0;
      abrt[d]  = 1'b0;
      a_in[d]  = $urandom;
      b_in[d]  = $urandom;
      sgn[d]   = 1'($urandom_range(0, 1));
      if (want) begin
         e.res = er;
         e.due = acc + k + 1;
         if (d == 0) sb0.push_back(e);
         else        sb1.push_back(e);
      end
      check($sformatf("busy_after_accept dut%0d", d), 64'(obusy[d]), 64'd1);
      check($sformatf("ready_after_accept dut%0d", d), 64'(oready[d]), 64'd0);
      @(negedge clk);
   endtask

   task automatic wait_drain(input int d);
      int guard;
      guard = 0;
      while (((d == 0) ? sb0.size() : sb1.size()) > 0 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (((d == 0) ? sb0.size() : sb1.size()) > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout dut%0d: got %0d pending results, want 0", d,
                  (d == 0) ? sb0.size() : sb1.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          acc;
      int          acc2;
      int          c0;
      int          rise;
      logic [31:0] ra, rb;
      logic        rs;

      rst_n = 1'b0;
      valid = '0;
      sgn   = '0;
      abrt  = '0;
      a_in  = '0;
      b_in  = '0;
      rmode[0] = 0;
      rmode[1] = 0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset_valid dut%0d", d), 64'(ovalid[d]), 64'd0);
         check($sformatf("reset_busy dut%0d", d), 64'(obusy[d]), 64'd0);
         check($sformatf("reset_result dut%0d", d), ores[d], 64'd0);
         check($sformatf("reset_ready dut%0d", d), 64'(oready[d]), 64'd0);
      end
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("ready_after_release dut%0d", d), 64'(oready[d]), 64'd1);
      end

      // 12 x 13 with the consumer stalled for five cycles.
      rmode[0] = 2;
      drive(0, 32'd12, 32'd13, 1'b0, 1'b0, 1'b1, 64'd156, 32, acc);
      wait_drain(0);
      repeat (5) @(negedge clk);
      check("stalled_result", ores[0], 64'd156);
      check("stalled_valid", 64'(ovalid[0]), 64'd1);
      rmode[0] = 0;

      drive(0, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 1'b1, 1'b0, 1'b1, 64'd144, 32, acc);
      drive(0, 32'd12, 32'hFFFF_FFF4, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF70, 32, acc);
      drive(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1,
            64'h4000_0000_0000_0000, 32, acc);
      drive(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1,
            64'hFFFF_FFFE_0000_0001, 32, acc);
      drive(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'd1, 32, acc);
      wait_drain(0);

      // Abort ten cycles into CALC, then an accept with a coincident abort.
      drive(0, 32'd100, 32'd77, 1'b0, 1'b0, 1'b0, 64'd0, 32, acc);
      repeat (9) @(negedge clk);
      rise    = n_rise[0];
      abrt[0] = 1'b1;
      @(posedge clk);
      #1 abrt[0] = 1'b0;
      check("abort_busy", 64'(obusy[0]), 64'd0);
      check("abort_ready", 64'(oready[0]), 64'd1);
      repeat (40) @(negedge clk);
      check("abort_no_valid", 64'(n_rise[0]), 64'(rise));
      drive(0, 32'd3, 32'd4, 1'b0, 1'b1, 1'b1, 64'd12, 32, acc);
      wait_drain(0);

      // Early-exit instance.
      drive(1, 32'd7, 32'd5, 1'b0, 1'b0, 1'b1, 64'd35, 3, acc);
      drive(1, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 64'd0, 1, acc);
      drive(1, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 1'b1, 1'b0, 1'b1, 64'd144, 4, acc);
      wait_drain(1);

      // Random traffic with a random consumer on both instances.
      rmode[0] = 1;
      rmode[1] = 1;
      for (int i = 0; i < 16; i++) begin
         ra = pick();
         rb = pick();
         rs = 1'($urandom_range(0, 1));
         drive(0, ra, rb, rs, 1'b0, 1'b1, ref_mult(ra, rb, rs), ref_k(rb, rs, 1'b0), acc);
      end
      wait_drain(0);
      for (int i = 0; i < 24; i++) begin
         ra = pick();
         rb = pick();
         rs = 1'($urandom_range(0, 1));
         drive(1, ra, rb, rs, 1'b0, 1'b1, ref_mult(ra, rb, rs), ref_k(rb, rs, 1'b1), acc);
      end
      wait_drain(1);
      rmode[0] = 0;
      rmode[1] = 0;
      repeat (4) @(negedge clk);

      // Asynchronous reset mid-CALC, then back-to-back pairs.
      drive(0, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 64'd0, 32, acc);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_valid", 64'(ovalid[0]), 64'd0);
      check("async_reset_busy", 64'(obusy[0]), 64'd0);
      check("async_reset_result", ores[0], 64'd0);
      check("async_reset_ready", 64'(oready[0]), 64'd0);
      check("async_reset_result_ee", ores[1], 64'd0);
      #1 rst_n = 1'b1;
      #0;
      check("ready_after_async_release", 64'(oready[0]), 64'd1);
      c0 = cyc;
      drive(0, 32'd2, 32'd3, 1'b0, 1'b0, 1'b1, 64'd6, 32, acc);
      drive(0, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1, 64'd30, 32, acc2);
      check("first_edge_accept", 64'(acc), 64'(c0 + 1));
      check("back_to_back_period", 64'(acc2 - acc), 64'd35);
      wait_drain(0);
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
